// File: rtl/display_scan_scheduler.sv
// Display scan scheduler: sequences eight hex nibbles through one shared,
// registered hex-to-7-segment decoder and holds each result on its own
// digit output. Supports leading-zero blanking and a one-deep pending load.
module display_scan_scheduler #(
    parameter logic [6:0]  BLANK_CODE = 7'b1111111,
    parameter int unsigned NUM_DIGITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] value,
    input  logic        blank_lz,
    output logic [3:0]  dec_binary,
    input  logic [6:0]  dec_display,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [6:0]  hex6,
    output logic [6:0]  hex7,
    output logic        busy,
    output logic        done
);

    localparam int unsigned IDX_W    = 3;
    localparam int unsigned VAL_W    = 32;
    localparam int unsigned SEG_W    = 7;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [VAL_W-1:0]   cap_val;
    logic               cap_blz;
    logic [VAL_W-1:0]   pend_val;
    logic               pend_blz;
    logic               pend_v;
    logic [SEG_W-1:0]   hex_q [8];
    logic [7:0]         keep_c;
    logic [IDX_W-1:0]   wr_idx_c;
    logic [SEG_W-1:0]   wr_seg_c;

    // Extract nibble i of a 32-bit word.
    function automatic logic [3:0] nib(input logic [VAL_W-1:0] v, input logic [IDX_W-1:0] i);
        nib = 4'(v >> {i, 2'b00});
    endfunction

    // Per-digit keep mask: a digit above the highest nonzero nibble is blanked
    // when blanking is enabled; digit 0 is always shown.
    always_comb begin
        logic seen;
        seen   = 1'b0;
        keep_c = 8'h01;
        for (int k = 7; k >= 1; k--) begin
            if (cap_val[4*k +: 4] != 4'h0) begin
                seen = 1'b1;
            end
            keep_c[k] = seen | ~cap_blz;
        end
    end

    // Digit being written this cycle and its pattern (decoder result or blank).
    always_comb begin
        wr_idx_c = (state == FLUSH) ? IDX_LAST : idx - IDX_W'(1);
        wr_seg_c = keep_c[wr_idx_c] ? dec_display : BLANK_CODE;
    end

    // Scan FSM, digit registers, pending load and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cap_val    <= '0;
            cap_blz    <= 1'b0;
            pend_val   <= '0;
            pend_blz   <= 1'b0;
            pend_v     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dec_binary <= 4'h0;
            for (int k = 0; k < 8; k++) begin
                hex_q[k] <= BLANK_CODE;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        state      <= RUN;
                        idx        <= '0;
                        cap_val    <= value;
                        cap_blz    <= blank_lz;
                        busy       <= 1'b1;
                        dec_binary <= value[3:0];
                        pend_v     <= 1'b0;
                    end else if (pend_v) begin
                        state      <= RUN;
                        idx        <= '0;
                        cap_val    <= pend_val;
                        cap_blz    <= pend_blz;
                        busy       <= 1'b1;
                        dec_binary <= pend_val[3:0];
                        pend_v     <= 1'b0;
                    end
                end
                RUN: begin
                    if (idx != '0) begin
                        hex_q[wr_idx_c] <= wr_seg_c;
                    end
                    if (idx == IDX_LAST) begin
                        state      <= FLUSH;
                        dec_binary <= 4'h0;
                    end else begin
                        idx        <= idx + IDX_W'(1);
                        dec_binary <= nib(cap_val, idx + IDX_W'(1));
                    end
                end
                FLUSH: begin
                    hex_q[wr_idx_c] <= wr_seg_c;
                    done            <= 1'b1;
                    if (pend_v) begin
                        state      <= RUN;
                        idx        <= '0;
                        cap_val    <= pend_val;
                        cap_blz    <= pend_blz;
                        dec_binary <= pend_val[3:0];
                        pend_v     <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    dec_binary <= 4'h0;
                end
            endcase
            // A load while busy (including the restart edge) becomes pending; last wins.
            if (load && (state == RUN || state == FLUSH)) begin
                pend_val <= value;
                pend_blz <= blank_lz;
                pend_v   <= 1'b1;
            end
        end
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];
    assign hex6 = hex_q[6];
    assign hex7 = hex_q[7];

endmodule
